sma_crossover_detector: RTL and testbench

//  Consumer of two fixed-window SMA output streams (fast and slow windows of the same price feed).

---
 rtl/sma_crossover_detector_pkg.sv | 21 ++
 rtl/sma_crossover_detector_if.sv | 27 ++
 rtl/sma_crossover_detector_pairer.sv | 62 ++++++
 rtl/sma_crossover_detector.sv | 128 ++++++++++++
 tb/tb_sma_crossover_detector.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sma_crossover_detector_pkg.sv
// Shared trading-pipeline types: regime and crossover FSM encodings, plus counter sizing.
package sma_crossover_detector_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    ABOVE   = 2'd1,
    BELOW   = 2'd2
  } regime_e;

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    ARMED    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  // A counter that must reach max_count; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sma_crossover_detector_if.sv
// Fast/slow SMA sample inputs and crossover-detector outputs.
interface sma_crossover_detector_if #(
  parameter int data_width = 8
);
  import sma_crossover_detector_pkg::*;

  logic [data_width-1:0] fast_in;
  logic                  fast_valid;
  logic [data_width-1:0] slow_in;
  logic                  slow_valid;
  logic                  buy;
  logic                  sell;
  regime_e               regime;
  logic                  eval_valid;
  logic                  overrun;

  modport master (
    output fast_in, fast_valid, slow_in, slow_valid,
    input  buy, sell, regime, eval_valid, overrun
  );

  modport slave (
    input  fast_in, fast_valid, slow_in, slow_valid,
    output buy, sell, regime, eval_valid, overrun
  );

endinterface

// File: rtl/sma_crossover_detector_pairer.sv
// Pairs fast/slow samples through one hold register each; pair is combinational in the completing cycle.
// No backpressure: a repeated sample overwrites its hold and sets sticky overrun.
module sma_crossover_detector_pairer #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] i_fast,
  input  logic                  i_fast_vld,
  input  logic [data_width-1:0] i_slow,
  input  logic                  i_slow_vld,
  output logic                  o_pair_vld,
  output logic [data_width-1:0] o_fast,
  output logic [data_width-1:0] o_slow,
  output logic                  o_overrun
);

  logic [data_width-1:0] r_fast;
  logic [data_width-1:0] r_slow;
  logic                  r_fast_full;
  logic                  r_slow_full;
  logic                  r_overrun;
  logic                  w_fast_full;
  logic                  w_slow_full;

  assign w_fast_full = r_fast_full | i_fast_vld;
  assign w_slow_full = r_slow_full | i_slow_vld;
  assign o_pair_vld  = w_fast_full & w_slow_full;
  assign o_fast      = i_fast_vld ? i_fast : r_fast;
  assign o_slow      = i_slow_vld ? i_slow : r_slow;
  assign o_overrun   = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fast      <= '0;
      r_slow      <= '0;
      r_fast_full <= 1'b0;
      r_slow_full <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (o_pair_vld) begin
        r_fast_full <= 1'b0;
        r_slow_full <= 1'b0;
      end else begin
        if (i_fast_vld) begin
          r_fast      <= i_fast;
          r_fast_full <= 1'b1;
        end
        if (i_slow_vld) begin
          r_slow      <= i_slow;
          r_slow_full <= 1'b1;
        end
      end
      // A second sample on a stream whose partner is still missing loses the older one.
      if ((i_fast_vld && r_fast_full && !i_slow_vld) ||
          (i_slow_vld && r_slow_full && !i_fast_vld)) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sma_crossover_detector.sv
// Hysteresis-filtered fast/slow SMA crossover detector with warmup and post-signal cooldown.
// Outputs reflect a pair one cycle after its completing valid; no backpressure.
module sma_crossover_detector
  import sma_crossover_detector_pkg::*;
#(
  parameter int data_width = 8,
  parameter int hyst       = 2,
  parameter int warmup     = 4,
  parameter int cooldown   = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  sma_crossover_detector_if.slave io_bus
);

  localparam int CNT_W = cnt_width((warmup > cooldown) ? warmup : cooldown);
  localparam state_e RESET_STATE = (warmup == 0) ? ARMED : WARMUP;
  localparam logic signed [data_width:0] HYST_S    = (data_width + 1)'(hyst);
  localparam logic        [CNT_W-1:0]    WARM_LAST = CNT_W'(warmup - 1);
  localparam logic        [CNT_W-1:0]    COOL_LOAD = CNT_W'(cooldown);
  localparam logic        [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  logic                         w_pair_vld;
  logic [data_width-1:0]        w_pair_fast;
  logic [data_width-1:0]        w_pair_slow;
  logic                         w_overrun;
  logic signed [data_width:0]   w_diff;
  regime_e                      w_cand;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  regime_e           r_regime, w_regime_nxt;
  logic              r_buy, w_buy_nxt;
  logic              r_sell, w_sell_nxt;
  logic              r_eval;

  sma_crossover_detector_pairer #(.data_width(data_width)) u_pairer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_fast     (io_bus.fast_in),
    .i_fast_vld (io_bus.fast_valid),
    .i_slow     (io_bus.slow_in),
    .i_slow_vld (io_bus.slow_valid),
    .o_pair_vld (w_pair_vld),
    .o_fast     (w_pair_fast),
    .o_slow     (w_pair_slow),
    .o_overrun  (w_overrun)
  );

  assign w_diff = $signed({1'b0, w_pair_fast}) - $signed({1'b0, w_pair_slow});

  always_comb begin
    w_cand = r_regime;
    if (w_diff > HYST_S) begin
      w_cand = ABOVE;
    end else if (w_diff < -HYST_S) begin
      w_cand = BELOW;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_regime_nxt = r_regime;
    w_buy_nxt    = 1'b0;
    w_sell_nxt   = 1'b0;
    if (w_pair_vld) begin
      case (r_state)
        WARMUP: begin
          if (r_cnt == WARM_LAST) begin
            w_state_nxt = ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ARMED: begin
          w_regime_nxt = w_cand;
          w_buy_nxt    = (r_regime == BELOW) && (w_cand == ABOVE);
          w_sell_nxt   = (r_regime == ABOVE) && (w_cand == BELOW);
          if ((w_buy_nxt || w_sell_nxt) && (cooldown != 0)) begin
            w_state_nxt = COOLDOWN;
            w_cnt_nxt   = COOL_LOAD;
          end
        end
        COOLDOWN: begin
          // Regime keeps tracking so the next signal needs a fresh crossing after exit.
          w_regime_nxt = w_cand;
          if (r_cnt <= CNT_ONE) begin
            w_state_nxt = ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = RESET_STATE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RESET_STATE;
      r_cnt    <= '0;
      r_regime <= UNKNOWN;
      r_buy    <= 1'b0;
      r_sell   <= 1'b0;
      r_eval   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_regime <= w_regime_nxt;
      r_buy    <= w_buy_nxt;
      r_sell   <= w_sell_nxt;
      r_eval   <= w_pair_vld;
    end
  end

  assign io_bus.buy        = r_buy;
  assign io_bus.sell       = r_sell;
  assign io_bus.regime     = r_regime;
  assign io_bus.eval_valid = r_eval;
  assign io_bus.overrun    = w_overrun;

endmodule

// File: tb/tb_sma_crossover_detector.sv
// Directed-vector bench for sma_crossover_detector at default parameters.
module tb_sma_crossover_detector;
  import sma_crossover_detector_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sma_crossover_detector_if #(.data_width(8)) bus ();

  sma_crossover_detector #(
    .data_width (8),
    .hyst       (2),
    .warmup     (4),
    .cooldown   (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // One stimulus cycle; returns 1 time unit after the capturing edge, valids dropped.
  task automatic send(input logic fv, input logic [7:0] f, input logic sv, input logic [7:0] s);
    @(negedge clk);
    bus.fast_valid = fv;
    bus.fast_in    = f;
    bus.slow_valid = sv;
    bus.slow_in    = s;
    @(posedge clk);
    #1;
    bus.fast_valid = 1'b0;
    bus.slow_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.fast_valid = 1'b0;
    bus.slow_valid = 1'b0;
    bus.fast_in    = '0;
    bus.slow_in    = '0;
    #12;
    checks++;
    if ({bus.buy, bus.sell, bus.eval_valid, bus.overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=0000", {bus.buy, bus.sell, bus.eval_valid, bus.overrun});
    end
    checks++;
    if (bus.regime !== UNKNOWN) begin
      failures++;
      $display("FAIL reset_regime got=%0d exp=%0d", bus.regime, UNKNOWN);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_warmup();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'd10, 1'b1, 8'd5);
      checks++;
      if (bus.eval_valid !== 1'b1 || bus.regime !== UNKNOWN || {bus.buy, bus.sell} !== 2'b00) begin
        failures++;
        $display("FAIL warmup_pair%0d got eval=%b regime=%0d buy=%b sell=%b exp eval=1 regime=0 buy=0 sell=0",
                 i, bus.eval_valid, bus.regime, bus.buy, bus.sell);
      end
    end
    idle();
    checks++;
    if (bus.eval_valid !== 1'b0) begin
      failures++;
      $display("FAIL warmup_idle_eval got=%b exp=0", bus.eval_valid);
    end
    send(1'b1, 8'd10, 1'b1, 8'd5);
    checks++;
    if (bus.regime !== ABOVE || bus.buy !== 1'b0 || bus.eval_valid !== 1'b1) begin
      failures++;
      $display("FAIL warmup_fifth got regime=%0d buy=%b eval=%b exp regime=1 buy=0 eval=1",
               bus.regime, bus.buy, bus.eval_valid);
    end
  endtask

  task automatic test_crossover();
    logic [7:0] fv [4] = '{8'd6, 8'd5, 8'd4, 8'd3};
    logic [7:0] sv [4] = '{8'd5, 8'd6, 8'd6, 8'd6};
    regime_e    er [4] = '{ABOVE, ABOVE, ABOVE, BELOW};
    logic       es [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(1'b1, fv[i], 1'b1, sv[i]);
      checks++;
      if (bus.regime !== er[i] || bus.sell !== es[i] || bus.buy !== 1'b0) begin
        failures++;
        $display("FAIL cross_pair%0d got regime=%0d sell=%b buy=%b exp regime=%0d sell=%b buy=0",
                 i, bus.regime, bus.sell, bus.buy, er[i], es[i]);
      end
    end
    idle();
    checks++;
    if (bus.sell !== 1'b0) begin
      failures++;
      $display("FAIL cross_sell_one_cycle got=%b exp=0", bus.sell);
    end
  endtask

  task automatic test_cooldown();
    logic [7:0] fv [5] = '{8'd9, 8'd3, 8'd9, 8'd9, 8'd2};
    logic [7:0] sv [5] = '{8'd5, 8'd6, 8'd5, 8'd5, 8'd6};
    regime_e    er [5] = '{ABOVE, BELOW, ABOVE, ABOVE, BELOW};
    logic       es [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      send(1'b1, fv[i], 1'b1, sv[i]);
      checks++;
      if (bus.regime !== er[i] || bus.sell !== es[i] || bus.buy !== 1'b0) begin
        failures++;
        $display("FAIL cooldown_pair%0d got regime=%0d sell=%b buy=%b exp regime=%0d sell=%b buy=0",
                 i, bus.regime, bus.sell, bus.buy, er[i], es[i]);
      end
    end
  endtask

  task automatic test_skewed();
    send(1'b1, 8'd4, 1'b0, 8'd0);
    checks++;
    if (bus.eval_valid !== 1'b0) begin
      failures++;
      $display("FAIL skew_cycle1 eval got=%b exp=0", bus.eval_valid);
    end
    for (int c = 2; c <= 3; c++) begin
      idle();
      checks++;
      if (bus.eval_valid !== 1'b0) begin
        failures++;
        $display("FAIL skew_cycle%0d eval got=%b exp=0", c, bus.eval_valid);
      end
    end
    send(1'b0, 8'd0, 1'b1, 8'd6);
    checks++;
    if (bus.eval_valid !== 1'b1 || bus.regime !== BELOW) begin
      failures++;
      $display("FAIL skew_cycle4 got eval=%b regime=%0d exp eval=1 regime=2", bus.eval_valid, bus.regime);
    end
    send(1'b1, 8'd4, 1'b1, 8'd6);
    checks++;
    if (bus.eval_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_pair got eval=%b overrun=%b exp eval=1 overrun=0", bus.eval_valid, bus.overrun);
    end
    idle();
    checks++;
    if (bus.eval_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_after eval got=%b exp=0", bus.eval_valid);
    end
  endtask

  task automatic test_overrun();
    send(1'b1, 8'd20, 1'b0, 8'd0);
    checks++;
    if (bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_first_fast got=%b exp=0", bus.overrun);
    end
    send(1'b1, 8'd30, 1'b0, 8'd0);
    checks++;
    if (bus.overrun !== 1'b1 || bus.eval_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_second_fast got overrun=%b eval=%b exp overrun=1 eval=0", bus.overrun, bus.eval_valid);
    end
    // 30 vs 25 lands ABOVE; a stale 20 would have landed BELOW. Still in cooldown, so no buy.
    send(1'b0, 8'd0, 1'b1, 8'd25);
    checks++;
    if (bus.eval_valid !== 1'b1 || bus.regime !== ABOVE || bus.buy !== 1'b0 || bus.overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pair got eval=%b regime=%0d buy=%b overrun=%b exp eval=1 regime=1 buy=0 overrun=1",
               bus.eval_valid, bus.regime, bus.buy, bus.overrun);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 8'd10, 1'b0, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.regime !== UNKNOWN || bus.overrun !== 1'b0 || {bus.buy, bus.sell, bus.eval_valid} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_outputs got regime=%0d overrun=%b pulses=%b exp regime=0 overrun=0 pulses=000",
               bus.regime, bus.overrun, {bus.buy, bus.sell, bus.eval_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'd0, 1'b1, 8'd5);
    checks++;
    if (bus.eval_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_hold_discarded eval got=%b exp=0", bus.eval_valid);
    end
    send(1'b1, 8'd10, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) send(1'b1, 8'd10, 1'b1, 8'd5);
      checks++;
      if (bus.eval_valid !== 1'b1 || bus.regime !== UNKNOWN) begin
        failures++;
        $display("FAIL midreset_warm%0d got eval=%b regime=%0d exp eval=1 regime=0", i, bus.eval_valid, bus.regime);
      end
    end
    send(1'b1, 8'd10, 1'b1, 8'd5);
    checks++;
    if (bus.regime !== ABOVE || bus.buy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_armed got regime=%0d buy=%b exp regime=1 buy=0", bus.regime, bus.buy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fv [5] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd10};
    logic [7:0] sv [5] = '{8'd6, 8'd6, 8'd6, 8'd6, 8'd5};
    regime_e    er [5] = '{BELOW, BELOW, BELOW, BELOW, ABOVE};
    logic       es [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       eb [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      send(1'b1, fv[i], 1'b1, sv[i]);
      checks++;
      if (bus.regime !== er[i] || bus.sell !== es[i] || bus.buy !== eb[i] || bus.eval_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_pair%0d got regime=%0d sell=%b buy=%b eval=%b exp regime=%0d sell=%b buy=%b eval=1",
                 i, bus.regime, bus.sell, bus.buy, bus.eval_valid, er[i], es[i], eb[i]);
      end
    end
    idle();
    checks++;
    if (bus.buy !== 1'b0 || bus.eval_valid !== 1'b0 || bus.regime !== ABOVE) begin
      failures++;
      $display("FAIL b2b_idle got buy=%b eval=%b regime=%0d exp buy=0 eval=0 regime=1",
               bus.buy, bus.eval_valid, bus.regime);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_warmup();
    test_crossover();
    test_cooldown();
    test_skewed();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
